// File: rtl/router_pkg.sv
// Shared types for the wormhole router output-port control path.
package router_pkg;

  typedef enum logic [1:0] {
    FT_HEAD      = 2'd0,
    FT_BODY      = 2'd1,
    FT_TAIL      = 2'd2,
    FT_HEAD_TAIL = 2'd3
  } FLIT_TYPE_t;

  typedef enum logic {
    OU_IDLE   = 1'b0,
    OU_ACTIVE = 1'b1
  } OU_STATE_t;

  typedef enum logic {
    PORT_FREE = 1'b0,
    PORT_BUSY = 1'b1
  } PORT_STATUS_t;

  // A tail or a single-flit packet releases the output lock.
  function automatic logic flit_is_tail(input logic [1:0] t);
    return (t == FT_TAIL) || (t == FT_HEAD_TAIL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic          found;
  logic [PW-1:0] idx;
  int            pos;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N) pos = pos - N;
      idx = PW'(pos);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter_unit.sv
// Per-output-port control: RR arbitration, head-to-tail lock, credit-gated
// registered flit output.
module router_output_arbiter_unit
  import router_pkg::*;
#(
  parameter int NUM_IN  = 5,
  parameter int FLIT_W  = 32,
  parameter int CREDITS = 4
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_IN-1:0]                 i_req,
  input  logic [NUM_IN-1:0]                 i_flit_valid,
  input  logic [NUM_IN-1:0][1:0]            i_flit_type,
  input  logic [NUM_IN-1:0][FLIT_W-1:0]     i_flit,
  input  logic                              i_credit_return,
  output logic [NUM_IN-1:0]                 o_grant,
  output logic [NUM_IN-1:0]                 o_pop,
  output logic                              o_flit_valid,
  output logic [1:0]                        o_flit_type,
  output logic [FLIT_W-1:0]                 o_flit,
  output logic [$clog2(CREDITS+1)-1:0]      o_credits,
  output logic                              o_busy,
  output logic                              o_credit_err
);

  localparam int PW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int CW = $clog2(CREDITS + 1);

  OU_STATE_t         state_q, state_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic              err_q, err_d;
  logic              fvld_q, fvld_d;
  logic [1:0]        ftype_q, ftype_d;
  logic [FLIT_W-1:0] flit_q, flit_d;

  logic [NUM_IN-1:0] arb_gnt;
  logic [FLIT_W-1:0] mux_flit;
  logic [1:0]        mux_type;
  logic              mux_vld;
  logic [PW-1:0]     gidx;
  logic              fire;
  PORT_STATUS_t      status;

  rr_arbiter #(.N(NUM_IN), .PW(PW)) u_arb (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt)
  );

  // AND-OR select over the one-hot grant; gidx is only used for the pointer.
  always_comb begin
    mux_flit = '0;
    mux_type = '0;
    mux_vld  = 1'b0;
    gidx     = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      mux_flit = mux_flit | (i_flit[i] & {FLIT_W{grant_q[i]}});
      mux_type = mux_type | (i_flit_type[i] & {2{grant_q[i]}});
      mux_vld  = mux_vld | (i_flit_valid[i] & grant_q[i]);
      gidx     = gidx | (PW'(i) & {PW{grant_q[i]}});
    end
  end

  assign fire = (state_q == OU_ACTIVE) && mux_vld && (cred_q != '0);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    fvld_d  = 1'b0;
    ftype_d = ftype_q;
    flit_d  = flit_q;
    case (state_q)
      OU_IDLE: begin
        if (|i_req) begin
          grant_d = arb_gnt;
          state_d = OU_ACTIVE;
        end
      end
      OU_ACTIVE: begin
        if (fire) begin
          fvld_d  = 1'b1;
          ftype_d = mux_type;
          flit_d  = mux_flit;
          if (flit_is_tail(mux_type)) begin
            state_d = OU_IDLE;
            grant_d = '0;
            ptr_d   = (gidx == PW'(NUM_IN - 1)) ? '0 : gidx + PW'(1);
          end
        end
      end
      default: state_d = OU_IDLE;
    endcase
  end

  // A return with the counter already full is dropped and flagged.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (fire && !i_credit_return) begin
      cred_d = cred_q - CW'(1);
    end else if (!fire && i_credit_return) begin
      if (cred_q == CW'(CREDITS)) err_d = 1'b1;
      else                        cred_d = cred_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OU_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cred_q  <= CW'(CREDITS);
      err_q   <= 1'b0;
      fvld_q  <= 1'b0;
      ftype_q <= '0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      fvld_q  <= fvld_d;
      ftype_q <= ftype_d;
      flit_q  <= flit_d;
    end
  end

  assign status       = (state_q == OU_ACTIVE) ? PORT_BUSY : PORT_FREE;
  assign o_busy       = (status == PORT_BUSY);
  assign o_grant      = grant_q;
  assign o_pop        = grant_q & {NUM_IN{fire}};
  assign o_flit_valid = fvld_q;
  assign o_flit_type  = ftype_q;
  assign o_flit       = flit_q;
  assign o_credits    = cred_q;
  assign o_credit_err = err_q;

endmodule

// File: tb/tb_router_output_arbiter_unit.sv
// Randomized + directed bench for router_output_arbiter_unit against a
// packet-level reference model (owner index, pointer, credit count).
module tb_router_output_arbiter_unit;

  localparam int N = 5;
  localparam int W = 32;
  localparam int C = 4;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [N-1:0]         i_req;
  logic [N-1:0]         i_flit_valid;
  logic [N-1:0][1:0]    i_flit_type;
  logic [N-1:0][W-1:0]  i_flit;
  logic                 i_credit_return;
  logic [N-1:0]         o_grant;
  logic [N-1:0]         o_pop;
  logic                 o_flit_valid;
  logic [1:0]           o_flit_type;
  logic [W-1:0]         o_flit;
  logic [2:0]           o_credits;
  logic                 o_busy;
  logic                 o_credit_err;

  router_output_arbiter_unit #(.NUM_IN(N), .FLIT_W(W), .CREDITS(C)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .i_req           (i_req),
    .i_flit_valid    (i_flit_valid),
    .i_flit_type     (i_flit_type),
    .i_flit          (i_flit),
    .i_credit_return (i_credit_return),
    .o_grant         (o_grant),
    .o_pop           (o_pop),
    .o_flit_valid    (o_flit_valid),
    .o_flit_type     (o_flit_type),
    .o_flit          (o_flit),
    .o_credits       (o_credits),
    .o_busy          (o_busy),
    .o_credit_err    (o_credit_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: who owns the output (-1 = nobody), RR start, credits.
  int         m_owner, m_ptr, m_cred;
  bit         m_err, m_ov, last_fire;
  logic [1:0] m_ot;
  logic [W-1:0] m_of;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_cred = C; m_err = 0;
    m_ov = 0; m_ot = '0; m_of = '0; last_fire = 0;
  endtask

  function automatic logic [9:0] all_ty(input logic [1:0] t);
    return {5{t}};
  endfunction

  // Compare DUT against the model for the current inputs, then advance one clock.
  task automatic check_and_step();
    bit fire;
    logic [N-1:0] eg, ep;
    logic [2:0] oi;
    oi   = 3'(m_owner < 0 ? 0 : m_owner);
    fire = (m_owner >= 0) && i_flit_valid[oi] && (m_cred > 0);
    eg   = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    ep   = fire ? eg : '0;
    chk("grant",   64'(o_grant), 64'(eg));
    chk("pop",     64'(o_pop), 64'(ep));
    chk("busy",    64'(o_busy), 64'(m_owner >= 0));
    chk("credits", 64'(o_credits), 64'(m_cred));
    chk("err",     64'(o_credit_err), 64'(m_err));
    chk("fvalid",  64'(o_flit_valid), 64'(m_ov));
    chk("ftype",   64'(o_flit_type), 64'(m_ot));
    chk("flit",    64'(o_flit), 64'(m_of));
    last_fire = fire;
    if (m_owner < 0) begin
      m_ov = 0;
      if (|i_req) begin
        for (int k = N - 1; k >= 0; k--)
          if (i_req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      end
    end else if (fire) begin
      m_ov = 1; m_ot = i_flit_type[oi]; m_of = i_flit[oi];
      if (m_ot >= 2) begin
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else begin
      m_ov = 0;
    end
    if (fire && !i_credit_return) m_cred--;
    else if (!fire && i_credit_return) begin
      if (m_cred == C) m_err = 1;
      else m_cred++;
    end
  endtask

  task automatic cyc(input logic [N-1:0] req, input logic [N-1:0] vld,
                     input logic [9:0] tys, input logic ret);
    i_req = req; i_flit_valid = vld; i_flit_type = tys; i_credit_return = ret;
    for (int i = 0; i < N; i++) i_flit[i] = $urandom;
    #1;
    check_and_step();
    @(negedge clk);
  endtask

  // Drive one packet on a lane; type follows the flits the model says were consumed.
  task automatic send_pkt(input int lane, input int n, input logic [31:0] ret_mask);
    int sent, c;
    logic [1:0] t;
    sent = 0; c = 0;
    while (sent < n && c < 40) begin
      if (sent == 0)      t = (n == 1) ? 2'd3 : 2'd0;
      else if (sent == n - 1) t = 2'd2;
      else                t = 2'd1;
      cyc(N'(1) << lane, N'(1) << lane, all_ty(t), (c < 32) ? ret_mask[c] : 1'b0);
      if (last_fire) sent++;
      c++;
    end
    chk("pkt_done", 64'(sent), 64'(n));
  endtask

  // Asynchronous reset between clock edges, with live inputs still applied.
  task automatic mid_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_grant",   64'(o_grant), 64'd0);
    chk("rst_pop",     64'(o_pop), 64'd0);
    chk("rst_fvalid",  64'(o_flit_valid), 64'd0);
    chk("rst_ftype",   64'(o_flit_type), 64'd0);
    chk("rst_flit",    64'(o_flit), 64'd0);
    chk("rst_busy",    64'(o_busy), 64'd0);
    chk("rst_err",     64'(o_credit_err), 64'd0);
    chk("rst_credits", 64'(o_credits), 64'(C));
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    i_req = '0; i_flit_valid = '0; i_flit_type = '0; i_flit = '0; i_credit_return = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cyc('0, '0, '0, 1'b0);

    // Single 3-flit packet on input 2, then idle; credits end at 1.
    send_pkt(2, 3, 32'h0);
    repeat (2) cyc('0, '0, '0, 1'b0);
    chk("t1_credits", 64'(o_credits), 64'd1);

    // Inputs 0 and 3 together, then everyone, single-flit packets.
    mid_reset();
    for (int i = 0; i < 4; i++) cyc(5'b01001, 5'b01001, all_ty(2'd3), 1'b0);
    for (int i = 0; i < 8; i++) cyc(5'b11111, 5'b11111, all_ty(2'd3), i[0]);

    // 6-flit packet on 4 credits: stall at zero, returns release one flit each.
    mid_reset();
    send_pkt(1, 6, 32'h0000_0280);
    repeat (2) cyc('0, '0, '0, 1'b0);

    // Credits at 2, fire and return together; single-flit packet.
    mid_reset();
    send_pkt(0, 2, 32'h0);
    send_pkt(4, 1, 32'h0000_0002);
    cyc('0, '0, '0, 1'b0);
    chk("t4_credits", 64'(o_credits), 64'd2);

    // Return at full count: error flag sticks until reset.
    mid_reset();
    cyc('0, '0, '0, 1'b1);
    repeat (3) cyc('0, '0, '0, 1'b0);
    chk("t5_err", 64'(o_credit_err), 64'd1);
    send_pkt(3, 1, 32'h0);

    // Reset after the body flit of a packet on input 3.
    mid_reset();
    cyc(5'b01000, 5'b01000, all_ty(2'd0), 1'b0);
    cyc(5'b01000, 5'b01000, all_ty(2'd0), 1'b0);
    cyc(5'b01000, 5'b01000, all_ty(2'd1), 1'b0);
    mid_reset();
    cyc(5'b00011, '0, '0, 1'b0);
    chk("t6_grant_ptr0", 64'(o_grant), 64'd1);

    // Random traffic with periodic resets.
    for (int n = 0; n < 3000; n++) begin
      logic [9:0] ty;
      for (int i = 0; i < N; i++) ty[2*i +: 2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(2, 3))
                                                                              : 2'($urandom_range(0, 1));
      cyc(N'($urandom), N'($urandom) | N'($urandom), ty, $urandom_range(0, 2) == 0);
      if (n % 400 == 399) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
